// File: rtl/com_uart.sv
// com_uart: 8N1 serial engine for the memory controller's com port (byte TX strobe, RX byte + ready flag).
// Build option COM_RX_FIFO_EN swaps the single RX holding register for a 2**RX_FIFO_AW-entry FIFO.
`timescale 1ns/1ps

module com_uart #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int RX_FIFO_AW = 2
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       uart_txd,
    input  logic       uart_rxd
);
    // state   | meaning
    // S_IDLE  | line idle (TX: ready for tx_start; RX: waiting for a low rxs)
    // S_START | start bit (RX: only half a bit, to land samples mid-bit)
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(DIV) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    uart_state_t   tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == BIT_END);

    always_ff @(posedge clk50M) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == S_IDLE) begin
                tx_cnt <= '0;
                tx_bit <= '0;
                if (tx_start) tx_shift <= tx_data;
            end else begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
                if (tx_state == S_DATA && tx_tick) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end
        end
    end

    always_comb begin
        tx_next  = tx_state;
        tx_ready = 1'b0;
        uart_txd = 1'b1;
        case (tx_state)
            S_IDLE: begin
                tx_ready = 1'b1;
                if (tx_start) tx_next = S_START;
            end
            S_START: begin
                uart_txd = 1'b0;
                if (tx_tick) tx_next = S_DATA;
            end
            S_DATA: begin
                uart_txd = tx_shift[0];
                if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            end
            S_STOP: begin
                if (tx_tick) tx_next = S_IDLE;
            end
            default: tx_next = S_IDLE;
        endcase
    end

    // uart_rxd is asynchronous; everything below looks only at rxs.
    logic rx_meta, rxs;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
        end
    end

    uart_state_t   rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_half, rx_tick, push, frame_err, overrun_c;
    logic          rx_ack_q, pop;

    assign rx_half = (rx_cnt == HALF_END);
    assign rx_tick = (rx_cnt == BIT_END);
    assign pop     = rx_ack & ~rx_ack_q;

    always_comb begin
        rx_next   = rx_state;
        push      = 1'b0;
        frame_err = 1'b0;
        case (rx_state)
            S_IDLE:  if (!rxs) rx_next = S_START;
            S_START: if (rx_half) rx_next = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP: begin
                if (rx_tick) begin
                    rx_next   = S_IDLE;
                    push      = rxs;
                    frame_err = ~rxs;
                end
            end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_ack_q     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_state     <= rx_next;
            rx_ack_q     <= rx_ack;
            rx_frame_err <= frame_err;
            rx_overrun   <= overrun_c;
            if (rx_state == S_IDLE || (rx_state == S_START && rx_half) || rx_tick)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_IDLE)
                rx_bit <= '0;
            if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rxs, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
        end
    end

`ifdef COM_RX_FIFO_EN
    localparam int DEPTH = 2 ** RX_FIFO_AW;

    logic [7:0]          fifo_mem [DEPTH];
    logic [RX_FIFO_AW:0] wr_ptr, rd_ptr;
    logic                empty, full, do_pop, do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[RX_FIFO_AW] != rd_ptr[RX_FIFO_AW]) &&
                       (wr_ptr[RX_FIFO_AW-1:0] == rd_ptr[RX_FIFO_AW-1:0]);
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign do_push   = push & (~full | do_pop);
    assign overrun_c = push & full & ~do_pop;
    assign rx_data   = fifo_mem[rd_ptr[RX_FIFO_AW-1:0]];
    assign rx_ready  = ~empty;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr[RX_FIFO_AW-1:0]] <= rx_shift;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
`else
    assign overrun_c = push & rx_ready & ~pop;

    always_ff @(posedge clk50M) begin
        if (rst) begin
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else if (push) begin
            rx_data  <= rx_shift;
            rx_ready <= 1'b1;
        end else if (pop) begin
            rx_ready <= 1'b0;
        end
    end
`endif

endmodule
